btn_toggle_debounce: RTL and testbench

Debounces a raw push-button input and turns it into the clean control events the LED stage consumes. It produces:
- a level `toggle` that flips on each completed short press, wired to the LED block's `toggle` input;
- one-cycle press, release and long-press pulses for the fall-detection control logic.

It sits directly upstream of the LED stage, between the board button pin and the LED driver.

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/btn_toggle_debounce.sv | 135 +++++++++++++
 tb/tb_btn_toggle_debounce.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debounce block.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // Convert a duration in milliseconds into clock cycles at freq Hz.
  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit board inputs.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; reset loads the input's inactive level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_toggle_debounce.sv
// Debounces a raw button into a level, press/release/long pulses and a toggle.
module btn_toggle_debounce
  import btn_pkg::*;
#(
  parameter int unsigned FREQUENCE   = 27_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  // DB_CYCLES must be >= 2 and LONG_CYCLES must exceed DB_CYCLES.
  localparam int unsigned DB_CYCLES   = ms_to_cycles(FREQUENCE, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(FREQUENCE, LONG_MS);
  localparam int unsigned DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned HOLD_W      = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic RELEASED_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  btn_state_t        state;
  logic              btn_sync;
  logic              pressed_s;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              long_hit;
  logic              long_fired;

  sync_2ff #(
    .RST_VAL(RELEASED_LVL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // Normalise polarity so 1 always means pressed.
  assign pressed_s = ACTIVE_LOW ? ~btn_sync : btn_sync;

  // Saturating hold counter step and one-shot long-press detect.
  always_comb begin
    hold_next = hold_cnt;
    long_hit  = 1'b0;
    if (hold_cnt == HOLD_LAST) begin
      long_hit = ~long_fired;
    end else begin
      hold_next = hold_cnt + HOLD_W'(1);
    end
  end

  // Debounce state machine with registered level, pulses and toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_fired    <= 1'b0;
      btn_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed_s) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!pressed_s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_state   <= 1'b1;
            hold_cnt    <= '0;
            long_fired  <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          hold_cnt <= hold_next;
          if (long_hit) begin
            long_pulse <= 1'b1;
            long_fired <= 1'b1;
          end
          if (!pressed_s) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
          end
        end
        RELEASE_CHK: begin
          if (!pressed_s && (db_cnt == DB_LAST)) begin
            // Release wins over a coincident long detect to keep pulses exclusive.
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_state     <= 1'b0;
            if (!long_fired) begin
              toggle <= ~toggle;
            end
          end else begin
            hold_cnt <= hold_next;
            if (long_hit) begin
              long_pulse <= 1'b1;
              long_fired <= 1'b1;
            end
            if (pressed_s) begin
              state <= HELD;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_toggle_debounce.sv
// Directed bench: active-low and active-high instances driven with mirrored stimulus.
module tb_btn_toggle_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic press;
  logic btn_a, btn_b;
  logic st_a, pp_a, rp_a, lp_a, tg_a;
  logic st_b, pp_b, rp_b, lp_b, tg_b;
  logic [4:0] o [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign btn_a = ~press;
  assign btn_b = press;
  assign o[0] = {st_a, pp_a, rp_a, lp_a, tg_a};
  assign o[1] = {st_b, pp_b, rp_b, lp_b, tg_b};

  btn_toggle_debounce #(
    .FREQUENCE(1000), .DEBOUNCE_MS(4), .LONG_MS(16), .ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .btn_state(st_a),
    .press_pulse(pp_a), .release_pulse(rp_a), .long_pulse(lp_a), .toggle(tg_a)
  );

  btn_toggle_debounce #(
    .FREQUENCE(1000), .DEBOUNCE_MS(4), .LONG_MS(16), .ACTIVE_LOW(1'b0)
  ) dut_high (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .btn_state(st_b),
    .press_pulse(pp_b), .release_pulse(rp_b), .long_pulse(lp_b), .toggle(tg_b)
  );

  // Expected output bits: {btn_state, press_pulse, release_pulse, long_pulse, toggle}
  typedef struct {
    logic        press;
    logic        rst;
    int unsigned n;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic r, input int unsigned n, input logic [4:0] e);
    vec_t v;
    v.press = p; v.rst = r; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic p, input logic r);
    press = p;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] e);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o[d] !== e) begin
        failures++;
        $display("FAIL %s dut%0d outs got=%b want=%b", name, d, o[d], e);
      end
      checks++;
      if ($countones(o[d][3:1]) > 1) begin
        failures++;
        $display("FAIL %s dut%0d pulse_excl got=%b want=at most one", name, d, o[d][3:1]);
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  int pp_at [2];
  int rp_at [2];
  int lp_at [2];
  int lp_n  [2];

  initial begin
    press = 1'b0;
    rst_n = 1'b0;

    // reset, then idle
    add(0, 0, 3, 5'b00000);
    add(0, 1, 2, 5'b00000);
    // clean short press: press after N+6, release after M+6, toggle 0->1
    add(1, 1, 6, 5'b00000);
    add(1, 1, 1, 5'b11000);
    add(1, 1, 3, 5'b10000);
    add(0, 1, 6, 5'b10000);
    add(0, 1, 1, 5'b00101);
    add(0, 1, 3, 5'b00001);
    // press bounce: 3 pressed, 2 released, 3 pressed, released
    add(1, 1, 3, 5'b00001);
    add(0, 1, 2, 5'b00001);
    add(1, 1, 3, 5'b00001);
    add(0, 1, 8, 5'b00001);
    // long press held 30 cycles: long after N+22, toggle unchanged on release
    add(1, 1, 6, 5'b00001);
    add(1, 1, 1, 5'b11001);
    add(1, 1, 15, 5'b10001);
    add(1, 1, 1, 5'b10011);
    add(1, 1, 7, 5'b10001);
    add(0, 1, 6, 5'b10001);
    add(0, 1, 1, 5'b00101);
    add(0, 1, 2, 5'b00001);
    // release glitch of 2 cycles while held: long still after N+22
    add(1, 1, 6, 5'b00001);
    add(1, 1, 1, 5'b11001);
    add(1, 1, 3, 5'b10001);
    add(0, 1, 2, 5'b10001);
    add(1, 1, 10, 5'b10001);
    add(1, 1, 1, 5'b10011);
    add(1, 1, 3, 5'b10001);
    // reset mid-hold with toggle=1, button kept held: fresh press 6 edges later
    add(1, 0, 1, 5'b00000);
    add(1, 1, 6, 5'b00000);
    add(1, 1, 1, 5'b11000);
    add(1, 1, 2, 5'b10000);
    add(0, 1, 6, 5'b10000);
    add(0, 1, 1, 5'b00101);
    add(0, 1, 2, 5'b00001);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        step(vecs[i].press, vecs[i].rst);
        check($sformatf("vec%0d_%0d", i, k), vecs[i].exp);
      end
    end

    // Long press that matures inside RELEASE_CHK: pulses once, release follows, no toggle.
    for (int d = 0; d < 2; d++) begin
      pp_at[d] = -1; rp_at[d] = -1; lp_at[d] = -1; lp_n[d] = 0;
    end
    for (int c = 0; c < 40; c++) begin
      step(c < 18, 1'b1);
      for (int d = 0; d < 2; d++) begin
        if (o[d][3] && pp_at[d] < 0) pp_at[d] = c;
        if (o[d][2] && rp_at[d] < 0) rp_at[d] = c;
        if (o[d][1]) begin
          lp_n[d]++;
          if (lp_at[d] < 0) lp_at[d] = c;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("late_long_press_at_dut%0d", d), pp_at[d], 6);
      cmp($sformatf("late_long_long_at_dut%0d", d), lp_at[d], 22);
      cmp($sformatf("late_long_long_count_dut%0d", d), lp_n[d], 1);
      cmp($sformatf("late_long_release_at_dut%0d", d), rp_at[d], 24);
    end
    check("late_long_final", 5'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
